// File: rtl/kanagawa_fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ requesters,
// with a bounded burst lock per grant and a registered write interface.
module kanagawa_fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         wrreq_out,
  output logic [WIDTH-1:0]             data_out,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  input  logic                         almost_full_in
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   grantIdx;
  logic               anyValid;
  logic               transfer;
  logic               wrreq_q;
  logic [WIDTH-1:0]   data_q;
  logic [IDX_W-1:0]   grant_q;

  function automatic logic [IDX_W-1:0] nextIdx(input logic [IDX_W-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    else return i + IDX_W'(1);
  endfunction

  // Scan from the highest offset down so the requester closest to ptr wins.
  always_comb begin
    winner   = '0;
    anyValid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
        winner   = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
        anyValid = 1'b1;
      end
    end
  end

  assign grantIdx = (state_q == BURST) ? owner_q : winner;

  always_comb begin
    req_ready = '0;
    if (!rst && !almost_full_in) begin
      if (state_q == IDLE) begin
        if (anyValid) req_ready[winner] = 1'b1;
      end else begin
        req_ready[owner_q] = req_valid[owner_q];
      end
    end
  end

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (transfer) begin
          if (MAX_BURST > 1) begin
            state_d = BURST;
            owner_d = winner;
            count_d = CNT_W'(1);
          end else begin
            ptr_d = nextIdx(winner);
          end
        end
      end
      BURST: begin
        // An owner dropping valid releases the grant even under back-pressure.
        if (!req_valid[owner_q]) begin
          state_d = IDLE;
          ptr_d   = nextIdx(owner_q);
          count_d = '0;
        end else if (transfer) begin
          if (count_q + CNT_W'(1) == CNT_W'(MAX_BURST)) begin
            state_d = IDLE;
            ptr_d   = nextIdx(owner_q);
            count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrreq_q <= 1'b0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      wrreq_q <= transfer;
      if (transfer) begin
        data_q  <= req_data[int'(grantIdx)*WIDTH +: WIDTH];
        grant_q <= grantIdx;
      end
    end
  end

  assign wrreq_out = wrreq_q;
  assign data_out  = data_q;
  assign grant_id  = grant_q;

endmodule

// File: tb/tb_kanagawa_fifo_write_arbiter.sv
// Directed bench for kanagawa_fifo_write_arbiter: a MAX_BURST=4 instance for
// burst/round-robin behaviour and a MAX_BURST=1 instance for per-word rotation.
module tb_kanagawa_fifo_write_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  reqValid;
  logic [63:0] reqData;
  logic [3:0]  reqReady;
  logic        wrreqOut;
  logic [15:0] dataOut;
  logic [1:0]  grantId;
  logic        almostFull;

  logic [3:0]  reqValidB;
  logic [3:0]  reqReadyB;
  logic        wrreqOutB;
  logic [15:0] dataOutB;
  logic [1:0]  grantIdB;
  logic        almostFullB;

  int checks;
  int failures;

  kanagawa_fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst), .req_valid(reqValid), .req_data(reqData),
    .req_ready(reqReady), .wrreq_out(wrreqOut), .data_out(dataOut),
    .grant_id(grantId), .almost_full_in(almostFull)
  );

  kanagawa_fifo_write_arbiter #(.NUM_REQ(4), .WIDTH(16), .MAX_BURST(1)) dutB (
    .clk(clk), .rst(rst), .req_valid(reqValidB), .req_data(reqData),
    .req_ready(reqReadyB), .wrreq_out(wrreqOutB), .data_out(dataOutB),
    .grant_id(grantIdB), .almost_full_in(almostFullB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Requester i always offers the word 16'hA000 | i*16'h0111.
  function automatic logic [15:0] wordOf(input int i);
    return 16'hA000 | 16'(i * 16'h0111);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle on the burst instance, check ready, then the registered outputs.
  task automatic applyStimulus(input string tag, input logic [3:0] valid, input logic afull,
                               input logic [3:0] expReady, input logic expWr,
                               input logic [1:0] expGid, input logic [15:0] expData);
    reqValid   = valid;
    almostFull = afull;
    #1;
    checkOutput({tag, "_ready"}, 32'(reqReady), 32'(expReady));
    tick();
    checkOutput({tag, "_wr"}, 32'(wrreqOut), 32'(expWr));
    checkOutput({tag, "_gid"}, 32'(grantId), 32'(expGid));
    checkOutput({tag, "_data"}, 32'(dataOut), 32'(expData));
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst        = 1'b1;
    almostFull = 1'b1;
    reqValid   = 4'b0000;
    #1;
    checkOutput("rst_wr", 32'(wrreqOut), 32'd0);
    checkOutput("rst_data", 32'(dataOut), 32'd0);
    checkOutput("rst_gid", 32'(grantId), 32'd0);
    tick();
    tick();
    rst        = 1'b0;
    almostFull = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    rst         = 1'b0;
    reqValid    = 4'b0000;
    reqValidB   = 4'b0000;
    almostFull  = 1'b1;
    almostFullB = 1'b1;
    reqData     = {wordOf(3), wordOf(2), wordOf(1), wordOf(0)};
    #3;
    rst = 1'b1;
    #1;
    checkOutput("init_ready", 32'(reqReady), 32'd0);
    doReset();

    // Single requester: 10 gapless words, bursts rolling over at 4 and 8.
    for (int c = 0; c < 10; c++)
      applyStimulus($sformatf("single%0d", c), 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, wordOf(0));
    applyStimulus("single_end", 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, wordOf(0));

    // All four valid: bursts of 4 in order 0,1,2,3,0 with no bubbles.
    doReset();
    for (int c = 0; c < 20; c++)
      applyStimulus($sformatf("rr%0d", c), 4'b1111, 1'b0, 4'b0001 << ((c / 4) % 4),
                    1'b1, 2'((c / 4) % 4), wordOf((c / 4) % 4));

    // Back-pressure for 3 cycles after word 2 of requester 1.
    doReset();
    applyStimulus("af_w1", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    applyStimulus("af_w2", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    for (int c = 0; c < 3; c++)
      applyStimulus($sformatf("af_hold%0d", c), 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, wordOf(1));
    applyStimulus("af_w3", 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    applyStimulus("af_w4", 4'b0011, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    applyStimulus("af_next", 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, wordOf(0));

    // Owner 2 drops after one word: one bubble, then requester 3.
    doReset();
    applyStimulus("drop_w", 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, wordOf(2));
    applyStimulus("drop_gap", 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd2, wordOf(2));
    applyStimulus("drop_r3", 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, wordOf(3));

    // Asynchronous reset in the middle of requester 1's burst.
    doReset();
    applyStimulus("ar_w1", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    applyStimulus("ar_w2", 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, wordOf(1));
    #2;
    rst = 1'b1;
    #1;
    checkOutput("ar_wr", 32'(wrreqOut), 32'd0);
    checkOutput("ar_data", 32'(dataOut), 32'd0);
    checkOutput("ar_gid", 32'(grantId), 32'd0);
    checkOutput("ar_ready", 32'(reqReady), 32'd0);
    almostFull = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    applyStimulus("ar_af0", 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    applyStimulus("ar_af1", 4'b0011, 1'b1, 4'b0000, 1'b0, 2'd0, 16'h0000);
    applyStimulus("ar_win", 4'b0011, 1'b0, 4'b0001, 1'b1, 2'd0, wordOf(0));

    // MAX_BURST=1 instance: requesters 0 and 2 alternate every cycle.
    doReset();
    reqValid    = 4'b0000;
    reqValidB   = 4'b0101;
    almostFullB = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      checkOutput($sformatf("mb1_ready%0d", c), 32'(reqReadyB),
                  (c % 2 == 0) ? 32'h1 : 32'h4);
      tick();
      checkOutput($sformatf("mb1_wr%0d", c), 32'(wrreqOutB), 32'd1);
      checkOutput($sformatf("mb1_gid%0d", c), 32'(grantIdB), (c % 2 == 0) ? 32'd0 : 32'd2);
      checkOutput($sformatf("mb1_data%0d", c), 32'(dataOutB),
                  32'(wordOf((c % 2 == 0) ? 0 : 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
